mp1_run_ctrl: RTL and testbench

Run/halt/step sequencer for the single-cycle microprocessor core in MP1_top. It holds the core in reset after system reset and gates core execution through a clock-enable (cpu_en). It starts, stops, and single-steps the core under external command, on a PC breakpoint, on a cycle budget, or on a decoded halt instruction. It also keeps an executed-cycle counter and a halt-cause code for debug and test.

---
 rtl/mp1_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_mp1_run_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mp1_run_ctrl.sv
// Run/halt/step sequencer for the MP1 core: holds the core in reset after boot,
// gates execution through cpu_en and records why and when the core stopped.
module mp1_run_ctrl #(
   parameter int PC_W        = 8,
   parameter int CNT_W       = 16,
   parameter int BOOT_CYCLES = 2
) (
   input  logic             MCLK,
   input  logic             RST,
   input  logic             start,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             restart,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   input  logic             halt_instr,
   input  logic [CNT_W-1:0] max_cycles,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [2:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

   localparam logic [2:0] CAUSE_NONE  = 3'd0;
   localparam logic [2:0] CAUSE_REQ   = 3'd1;
   localparam logic [2:0] CAUSE_BP    = 3'd2;
   localparam logic [2:0] CAUSE_LIMIT = 3'd3;
   localparam logic [2:0] CAUSE_INSTR = 3'd4;
   localparam logic [2:0] CAUSE_STEP  = 3'd5;

   typedef enum logic [2:0] {
      BOOT = 3'd0,
      IDLE = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      HALT = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [BW-1:0]    boot_cnt, boot_cnt_nxt;
   logic [CNT_W-1:0] cycle_cnt_nxt;
   logic [2:0]       cause_nxt;
   logic             bp_mask, bp_mask_nxt;
   logic             limit_hit, bp_hit, stop_now;
   logic             en;

   // NOTE: every variable driven here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      limit_hit     = (max_cycles != '0) && (cycle_cnt >= max_cycles);
      bp_hit        = bp_en && (pc == bp_addr) && !bp_mask;
      stop_now      = limit_hit || halt_req || bp_hit || halt_instr;

      state_nxt     = state;
      boot_cnt_nxt  = boot_cnt;
      cycle_cnt_nxt = cycle_cnt;
      cause_nxt     = halt_cause;
      bp_mask_nxt   = bp_mask;
      en            = 1'b0;

      case (state)
         BOOT: begin
            if (boot_cnt == BOOT_LAST) state_nxt = IDLE;
            else                       boot_cnt_nxt = boot_cnt + 1'b1;
         end
         IDLE: begin
            if (start) begin
               state_nxt     = RUN;
               cycle_cnt_nxt = '0;
               cause_nxt     = CAUSE_NONE;
               bp_mask_nxt   = 1'b0;
            end
         end
         RUN: begin
            if (stop_now) begin
               state_nxt = HALT;
               if (limit_hit)     cause_nxt = CAUSE_LIMIT;
               else if (halt_req) cause_nxt = CAUSE_REQ;
               else if (bp_hit)   cause_nxt = CAUSE_BP;
               else               cause_nxt = CAUSE_INSTR;
            end else begin
               en          = 1'b1;
               bp_mask_nxt = 1'b0;
            end
         end
         STEP: begin
            // A step ignores breakpoint, halt_req and budget, but never
            // commits a HALT instruction.
            state_nxt = HALT;
            if (halt_instr) begin
               cause_nxt = CAUSE_INSTR;
            end else begin
               en        = 1'b1;
               cause_nxt = CAUSE_STEP;
            end
         end
         HALT: begin
            if (restart) begin
               state_nxt    = BOOT;
               boot_cnt_nxt = '0;
            end else if (step_req) begin
               state_nxt = STEP;
            end else if (start) begin
               state_nxt   = RUN;
               bp_mask_nxt = 1'b1;
               cause_nxt   = CAUSE_NONE;
            end
         end
         default: begin
            state_nxt    = BOOT;
            boot_cnt_nxt = '0;
         end
      endcase

      if (en && (cycle_cnt != '1)) cycle_cnt_nxt = cycle_cnt + 1'b1;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge MCLK) begin
      if (RST) begin
         state      <= BOOT;
         boot_cnt   <= '0;
         cycle_cnt  <= '0;
         halt_cause <= CAUSE_NONE;
         bp_mask    <= 1'b0;
      end else begin
         state      <= state_nxt;
         boot_cnt   <= boot_cnt_nxt;
         cycle_cnt  <= cycle_cnt_nxt;
         halt_cause <= cause_nxt;
         bp_mask    <= bp_mask_nxt;
      end
   end

   // The core must not commit on an edge that also resets this controller.
   assign cpu_en  = en && !RST;
   assign cpu_rst = (state == BOOT);
   assign running = (state == RUN) || (state == STEP);
   assign halted  = (state == HALT);

endmodule

// File: tb/tb_mp1_run_ctrl.sv
// Directed bench for mp1_run_ctrl; a tiny core model advances pc on cpu_en
// and clears it while cpu_rst is high.
module tb_mp1_run_ctrl;

   logic        MCLK = 1'b0;
   logic        RST, start, halt_req, step_req, restart, bp_en, halt_instr;
   logic [7:0]  bp_addr;
   logic [7:0]  pc = 8'd0;
   logic [15:0] max_cycles;
   logic        cpu_rst, cpu_en, running, halted;
   logic [2:0]  halt_cause;
   logic [15:0] cycle_cnt;
   logic        hi_en;
   int          en_edges = 0;
   int          en0;
   int          checks = 0;
   int          errors = 0;

   mp1_run_ctrl #(.PC_W(8), .CNT_W(16), .BOOT_CYCLES(2)) dut (
      .MCLK(MCLK), .RST(RST), .start(start), .halt_req(halt_req),
      .step_req(step_req), .restart(restart), .bp_en(bp_en), .bp_addr(bp_addr),
      .pc(pc), .halt_instr(halt_instr), .max_cycles(max_cycles),
      .cpu_rst(cpu_rst), .cpu_en(cpu_en), .running(running), .halted(halted),
      .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
   );

   always #5 MCLK = ~MCLK;

   always @(posedge MCLK) begin
      if (cpu_rst)     pc <= 8'd0;
      else if (cpu_en) pc <= pc + 8'd1;
      if (cpu_en) en_edges <= en_edges + 1;
   end

   always_comb halt_instr = hi_en && (pc == 8'd3);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge MCLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; start = 0; halt_req = 0; step_req = 0; restart = 0;
      bp_en = 0; bp_addr = 8'd0; max_cycles = 16'd0; hi_en = 0;

      // Reset and boot hold
      cyc();
      RST = 1'b0;
      #2;
      check("boot_rst0", cpu_rst, 1);
      check("boot_en0", cpu_en, 0);
      check("boot_run", running, 0);
      check("boot_halted", halted, 0);
      check("boot_cnt", cycle_cnt, 0);
      check("boot_cause", halt_cause, 0);
      cyc();
      check("boot_rst1", cpu_rst, 1);
      cyc();
      check("idle_rst", cpu_rst, 0);
      check("idle_en", cpu_en, 0);

      // step_req in IDLE is ignored
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      check("idle_ign_run", running, 0);
      check("idle_ign_halt", halted, 0);

      // Free run for 20 cycles, then halt_req
      start = 1'b1;
      #2;
      check("idle_start_en", cpu_en, 0);
      cyc();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #2;
         check("run_en", cpu_en, 1);
         cyc();
      end
      check("run_cnt20", cycle_cnt, 20);
      check("run_running", running, 1);
      check("run_pc20", pc, 20);
      halt_req = 1'b1;
      #2;
      check("req_en", cpu_en, 0);
      cyc();
      halt_req = 1'b0;
      check("req_halted", halted, 1);
      check("req_cause", halt_cause, 1);
      check("req_cnt", cycle_cnt, 20);

      // Restart keeps cycle_cnt, then breakpoint at 5
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      check("rs_rst", cpu_rst, 1);
      check("rs_cnt_kept", cycle_cnt, 20);
      cyc();
      cyc();
      check("rs_idle", cpu_rst, 0);
      check("rs_pc0", pc, 0);
      bp_en = 1'b1; bp_addr = 8'd5; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      #2;
      check("bp_pc", pc, 5);
      check("bp_en_drop", cpu_en, 0);
      cyc();
      check("bp_halted", halted, 1);
      check("bp_cause", halt_cause, 2);
      check("bp_cnt", cycle_cnt, 5);

      // Resume executes the instruction at the breakpoint
      start = 1'b1;
      cyc();
      start = 1'b0;
      #2;
      check("res_en_at_bp", cpu_en, 1);
      check("res_cause", halt_cause, 0);
      check("res_running", running, 1);
      cyc();
      #2;
      check("res_en6", cpu_en, 1);
      cyc();
      check("res_cnt7", cycle_cnt, 7);
      check("res_pc7", pc, 7);

      // RST mid-run
      RST = 1'b1;
      #2;
      check("rst_en", cpu_en, 0);
      cyc();
      RST = 1'b0;
      check("rst_boot", cpu_rst, 1);
      check("rst_cnt", cycle_cnt, 0);
      check("rst_cause", halt_cause, 0);
      check("rst_running", running, 0);
      cyc();
      cyc();
      check("rst_idle", cpu_rst, 0);

      // Halt at breakpoint 5, then three single steps through a bp at 6
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      #2;
      check("st_bp_en", cpu_en, 0);
      cyc();
      check("st_bp_cause", halt_cause, 2);
      bp_addr = 8'd6;
      en0 = en_edges;
      for (int k = 0; k < 3; k++) begin
         step_req = 1'b1;
         cyc();
         step_req = 1'b0;
         #2;
         check("step_en", cpu_en, 1);
         cyc();
         check("step_halted", halted, 1);
         check("step_cause", halt_cause, 5);
      end
      check("step_pc", pc, 8);
      check("step_cnt", cycle_cnt, 8);
      check("step_pulses", en_edges - en0, 3);

      // Budget of 10 coinciding with halt_req: limit wins
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      cyc();
      cyc();
      bp_en = 1'b0; max_cycles = 16'd10; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (10) cyc();
      halt_req = 1'b1;
      #2;
      check("lim_en", cpu_en, 0);
      check("lim_cnt_pre", cycle_cnt, 10);
      cyc();
      halt_req = 1'b0;
      check("lim_halted", halted, 1);
      check("lim_cause", halt_cause, 3);
      check("lim_cnt", cycle_cnt, 10);

      // HALT instruction at pc 3, step refused
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      cyc();
      cyc();
      max_cycles = 16'd0; hi_en = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (3) cyc();
      #2;
      check("hi_en_drop", cpu_en, 0);
      cyc();
      check("hi_cause", halt_cause, 4);
      check("hi_cnt", cycle_cnt, 3);
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      #2;
      check("hi_step_en", cpu_en, 0);
      check("hi_step_running", running, 1);
      cyc();
      check("hi_step_cause", halt_cause, 4);
      check("hi_step_cnt", cycle_cnt, 3);
      check("hi_step_pc", pc, 3);
      check("hi_step_halted", halted, 1);

      // Restart: two boot cycles then IDLE
      hi_en = 1'b0;
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      check("rb_rst0", cpu_rst, 1);
      check("rb_halted", halted, 0);
      cyc();
      check("rb_rst1", cpu_rst, 1);
      cyc();
      check("rb_idle_rst", cpu_rst, 0);
      check("rb_idle_en", cpu_en, 0);
      check("rb_idle_run", running, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
